// File: rtl/hulohot_alu_pipe.sv
// hulohot_alu_pipe: handshaked, registered ALU with an optional iterative multiplier.
//
// One operation is accepted per input transfer (in_valid && in_ready). The result, with its
// zero and err flags, is held in an output register until it is consumed
// (out_valid && out_ready). Single-cycle ops sustain one result per clock. When ALU_MUL_EN is
// defined, opcode 111 runs a shift-add multiply taking WIDTH+1 cycles. When it is undefined,
// opcode 111 completes in one cycle with err=1.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is combinational from state and out_ready
//   a, b                unsigned WIDTH-bit operands
//   opcode              000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   out_valid/out_ready result handshake
//   z                   2*WIDTH-bit result, zero-extended
//   zero, err           z == 0; illegal/disabled opcode (forces z=0, zero=1)
//
// Configuration macro: ALU_MUL_EN (enables the iterative multiplier and the BUSY state).

module hulohot_alu_pipe #(
  parameter int unsigned WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               zero,
  output logic               err
);

  localparam int unsigned ZW = 2 * WIDTH;
  // Shift amounts at or above WIDTH produce zero.
  localparam logic [WIDTH:0] ShLimit = (WIDTH+1)'(WIDTH);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;

`ifdef ALU_MUL_EN
  localparam logic [2:0]  OpMul   = 3'b111;
  localparam int unsigned CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StFull} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFull} state_e;
`endif

  state_e          state_q, state_d;
  logic [ZW-1:0]   z_q, z_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [ZW-1:0]   op_res;
  logic            op_err;
  logic            in_fire;
  logic            mul_req;

`ifdef ALU_MUL_EN
  logic [ZW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [ZW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign mul_req = (opcode == OpMul);
`else
  assign mul_req = 1'b0;
`endif

  assign out_valid = (state_q == StFull);
  assign in_ready  = (state_q == StIdle) || ((state_q == StFull) && out_ready);
  assign in_fire   = in_valid && in_ready;

  // Single-cycle datapath; only reaches the outputs through the result register.
  always_comb begin
    op_res = '0;
    op_err = 1'b0;
    case (opcode)
      OpAdd:   op_res[WIDTH:0]   = {1'b0, a} + {1'b0, b};
      OpSub:   op_res[WIDTH:0]   = {1'b0, a} - {1'b0, b};
      OpAnd:   op_res[WIDTH-1:0] = a & b;
      OpOr:    op_res[WIDTH-1:0] = a | b;
      OpXor:   op_res[WIDTH-1:0] = a ^ b;
      OpShl:   op_res[WIDTH-1:0] = ({1'b0, b} >= ShLimit) ? '0 : (a << b);
      OpShr:   op_res[WIDTH-1:0] = ({1'b0, b} >= ShLimit) ? '0 : (a >> b);
      default: begin
`ifndef ALU_MUL_EN
        op_err = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    zero_d  = zero_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle, StFull: begin
        if (out_valid && out_ready) state_d = StIdle;
        // In FULL an input transfer implies out_ready, so this also covers back-to-back.
        if (in_fire) begin
          if (mul_req) begin
`ifdef ALU_MUL_EN
            state_d  = StBusy;
            mcand_d  = ZW'(a);
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
`endif
          end else begin
            state_d = StFull;
            z_d     = op_err ? '0 : op_res;
            zero_d  = op_err || (op_res == '0);
            err_d   = op_err;
          end
        end
      end
`ifdef ALU_MUL_EN
      StBusy: begin
        if (cnt_q == CntLast) begin
          state_d = StFull;
          z_d     = acc_q;
          zero_d  = (acc_q == '0);
          err_d   = 1'b0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      z_q     <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign z    = z_q;
  assign zero = zero_q;
  assign err  = err_q;

endmodule
